// File: rtl/fpu_chk_pkg.sv
// fpu_chk_pkg: shared types and constants for the FPU exception-flag checker.
// Revision: 1.0
`default_nettype none

package fpu_chk_pkg;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } opclass_t;

    typedef struct packed {
        logic qnan;
        logic inf;
        logic dbz;
        logic zero;
    } exp_flags_t;

    localparam logic [2:0] FPU_ADD = 3'd0;
    localparam logic [2:0] FPU_SUB = 3'd1;
    localparam logic [2:0] FPU_MUL = 3'd2;
    localparam logic [2:0] FPU_DIV = 3'd3;

    localparam int ERR_W       = 5;
    localparam int ERR_QNAN    = 0;
    localparam int ERR_INF     = 1;
    localparam int ERR_DBZ     = 2;
    localparam int ERR_ZERO    = 3;
    localparam int ERR_NAN_OUT = 4;

endpackage

`default_nettype wire

// File: rtl/fpu_opclass.sv
// fpu_opclass: combinational zero/inf/NaN classifier for one IEEE-style operand.
// Revision: 1.0
`default_nettype none

module fpu_opclass
    import fpu_chk_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] value,
    output opclass_t             cls
);

    logic [EXP_W-1:0] exp_field;
    logic [MAN_W-1:0] man_field;
    logic             unused_sign;

    assign exp_field   = value[EXP_W+MAN_W-1:MAN_W];
    assign man_field   = value[MAN_W-1:0];
    assign unused_sign = value[EXP_W+MAN_W];

    // Denormals (exp==0, man!=0) fall through as finite non-zero.
    assign cls.is_nan  = (&exp_field) & (|man_field);
    assign cls.is_inf  = (&exp_field) & ~(|man_field);
    assign cls.is_zero = ~(|exp_field) & ~(|man_field);

endmodule

`default_nettype wire

// File: rtl/fpu_flag_checker.sv
// fpu_flag_checker: predicts FPU exception flags, delays them LATENCY cycles and
// compares against the FPU outputs, keeping sticky bits and saturating counters.
`default_nettype none

module fpu_flag_checker
    import fpu_chk_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   opa,
    input  logic [EXP_W+MAN_W:0]   opb,
    input  logic [2:0]             fpu_op,
    input  logic [EXP_W+MAN_W:0]   dut_out,
    input  logic                   dut_qnan,
    input  logic                   dut_inf,
    input  logic                   dut_dbz,
    input  logic                   dut_zero,
    input  logic                   clear,
    output logic                   err_pulse,
    output logic [ERR_W-1:0]       err_vec,
    output logic [ERR_W-1:0]       err_sticky,
    output logic [CNT_W-1:0]       chk_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int W = 1 + EXP_W + MAN_W;

    opclass_t   cls_a;
    opclass_t   cls_b;
    opclass_t   cls_o;
    exp_flags_t pred;
    logic       pred_valid;
    logic       eff_sub;
    logic       fin_a;
    logic       fin_b;

    fpu_opclass #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.value(opa),     .cls(cls_a));
    fpu_opclass #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.value(opb),     .cls(cls_b));
    fpu_opclass #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_o (.value(dut_out), .cls(cls_o));

    assign fin_a      = ~cls_a.is_nan & ~cls_a.is_inf;
    assign fin_b      = ~cls_b.is_nan & ~cls_b.is_inf;
    assign pred_valid = in_valid & (fpu_op <= FPU_DIV);

    always_comb begin
        pred      = '0;
        eff_sub   = 1'b0;
        pred.qnan = cls_a.is_nan | cls_b.is_nan;
        case (fpu_op)
            FPU_ADD, FPU_SUB: begin
                eff_sub   = opa[W-1] ^ opb[W-1] ^ (fpu_op == FPU_SUB);
                pred.qnan = pred.qnan | (cls_a.is_inf & cls_b.is_inf & eff_sub);
                pred.inf  = ~pred.qnan & (cls_a.is_inf | cls_b.is_inf);
            end
            FPU_MUL: begin
                pred.qnan = pred.qnan | (cls_a.is_zero & cls_b.is_inf)
                                      | (cls_a.is_inf & cls_b.is_zero);
                pred.inf  = ~pred.qnan & ((cls_a.is_inf & ~cls_b.is_zero)
                                        | (cls_b.is_inf & ~cls_a.is_zero));
                pred.zero = ~pred.qnan & ((cls_a.is_zero & fin_b)
                                        | (cls_b.is_zero & fin_a));
            end
            FPU_DIV: begin
                pred.qnan = pred.qnan | (cls_a.is_zero & cls_b.is_zero)
                                      | (cls_a.is_inf & cls_b.is_inf);
                pred.inf  = ~pred.qnan & ((cls_a.is_inf & ~cls_b.is_inf)
                                        | (fin_a & ~cls_a.is_zero & cls_b.is_zero));
                pred.dbz  = cls_b.is_zero & fin_a & ~cls_a.is_zero;
                pred.zero = ~pred.qnan & ((cls_a.is_zero & ~cls_b.is_zero)
                                        | (fin_a & cls_b.is_inf));
            end
            default: pred = '0;
        endcase
    end

    // Free-running delay line; reset flushes every in-flight prediction.
    logic       [LATENCY-1:0] pipe_v;
    exp_flags_t [LATENCY-1:0] pipe_f;

    generate
        if (LATENCY == 1) begin : g_lat_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_v <= '0;
                    pipe_f <= '0;
                end else begin
                    pipe_v[0] <= pred_valid;
                    pipe_f[0] <= pred;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_v <= '0;
                    pipe_f <= '0;
                end else begin
                    pipe_v <= {pipe_v[LATENCY-2:0], pred_valid};
                    pipe_f <= {pipe_f[LATENCY-2:0], pred};
                end
            end
        end
    endgenerate

    logic             tail_v;
    exp_flags_t       tail_f;
    logic [ERR_W-1:0] cmp_vec;

    assign tail_v = pipe_v[LATENCY-1];
    assign tail_f = pipe_f[LATENCY-1];

    // inf/zero are one-directional: overflow/underflow may legally raise them.
    always_comb begin
        cmp_vec              = '0;
        cmp_vec[ERR_QNAN]    = dut_qnan != tail_f.qnan;
        cmp_vec[ERR_INF]     = tail_f.inf & ~dut_inf;
        cmp_vec[ERR_DBZ]     = dut_dbz != tail_f.dbz;
        cmp_vec[ERR_ZERO]    = tail_f.zero & ~dut_zero;
        cmp_vec[ERR_NAN_OUT] = cls_o.is_nan != dut_qnan;
    end

    // A clear coinciding with a compare wipes history first, then counts that compare.
    logic [CNT_W-1:0] chk_base;
    logic [CNT_W-1:0] err_base;
    logic [ERR_W-1:0] sticky_base;
    logic [CNT_W-1:0] chk_next;
    logic [CNT_W-1:0] err_next;

    assign chk_base    = clear ? '0 : chk_cnt;
    assign err_base    = clear ? '0 : err_cnt;
    assign sticky_base = clear ? '0 : err_sticky;
    assign chk_next    = (&chk_base) ? chk_base : chk_base + CNT_W'(1);
    assign err_next    = (&err_base) ? err_base : err_base + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            err_vec    <= '0;
            err_sticky <= '0;
            chk_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            err_pulse <= tail_v & (|cmp_vec);
            if (tail_v) begin
                err_vec    <= cmp_vec;
                err_sticky <= sticky_base | cmp_vec;
                chk_cnt    <= chk_next;
                err_cnt    <= (|cmp_vec) ? err_next : err_base;
            end else if (clear) begin
                err_sticky <= '0;
                chk_cnt    <= '0;
                err_cnt    <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_flag_checker.sv
// tb_fpu_flag_checker: directed and randomized checks of fpu_flag_checker against
// a class-based reference model of the expected FPU exception behaviour.
`default_nettype none

module tb_fpu_flag_checker;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] opa = '0, opb = '0, dut_out = '0;
    logic [2:0]  fpu_op = '0;
    logic        dut_qnan = 1'b0, dut_inf = 1'b0, dut_dbz = 1'b0, dut_zero = 1'b0;
    logic        clear = 1'b0;

    logic        err_pulse, err_pulse4;
    logic [4:0]  err_vec, err_sticky, err_vec4, err_sticky4;
    logic [15:0] chk_cnt, err_cnt;
    logic [3:0]  chk_cnt4, err_cnt4;

    int errors = 0;
    int checks = 0;

    fpu_flag_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opa(opa), .opb(opb), .fpu_op(fpu_op),
        .dut_out(dut_out), .dut_qnan(dut_qnan), .dut_inf(dut_inf), .dut_dbz(dut_dbz),
        .dut_zero(dut_zero), .clear(clear), .err_pulse(err_pulse), .err_vec(err_vec),
        .err_sticky(err_sticky), .chk_cnt(chk_cnt), .err_cnt(err_cnt)
    );

    fpu_flag_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opa(opa), .opb(opb), .fpu_op(fpu_op),
        .dut_out(dut_out), .dut_qnan(dut_qnan), .dut_inf(dut_inf), .dut_dbz(dut_dbz),
        .dut_zero(dut_zero), .clear(clear), .err_pulse(err_pulse4), .err_vec(err_vec4),
        .err_sticky(err_sticky4), .chk_cnt(chk_cnt4), .err_cnt(err_cnt4)
    );

    always #5 clk = ~clk;

    // Reference model state: pending predictions {valid, qnan, inf, dbz, zero}.
    logic [4:0] pend[$];
    logic       m_pulse;
    logic [4:0] m_vec, m_sticky;
    int         m_chk, m_err, m_chk4, m_err4;

    localparam int C_ZERO = 0, C_FIN = 1, C_INF = 2, C_NAN = 3;

    function automatic int cls(input logic [31:0] x);
        if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? C_NAN : C_INF;
        if (x[30:0] == 0) return C_ZERO;
        return C_FIN;
    endfunction

    // Result class of the exact operation, then flags derived from that class.
    function automatic logic [3:0] predict(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        int  ca = cls(a);
        int  cb = cls(b);
        int  res = C_FIN;
        bit  dbz = 0;
        bit  sb;
        if (ca == C_NAN || cb == C_NAN) res = C_NAN;
        else if (op <= 3'd1) begin
            sb = b[31] ^ (op == 3'd1);
            if (ca == C_INF && cb == C_INF) res = (a[31] == sb) ? C_INF : C_NAN;
            else if (ca == C_INF || cb == C_INF) res = C_INF;
        end else if (op == 3'd2) begin
            if ((ca == C_ZERO && cb == C_INF) || (ca == C_INF && cb == C_ZERO)) res = C_NAN;
            else if (ca == C_INF || cb == C_INF) res = C_INF;
            else if (ca == C_ZERO || cb == C_ZERO) res = C_ZERO;
        end else begin
            if ((ca == C_ZERO && cb == C_ZERO) || (ca == C_INF && cb == C_INF)) res = C_NAN;
            else if (ca == C_INF) res = C_INF;
            else if (cb == C_ZERO) begin res = C_INF; dbz = 1; end
            else if (ca == C_ZERO || cb == C_INF) res = C_ZERO;
        end
        return {res == C_NAN, res == C_INF, dbz, res == C_ZERO};
    endfunction

    task automatic tick(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] o,
                        input bit q, input bit i, input bit d, input bit z,
                        input bit clr, input bit r);
        logic [4:0] tail;
        logic [4:0] vec;
        in_valid = v; opa = a; opb = b; fpu_op = op; dut_out = o;
        dut_qnan = q; dut_inf = i; dut_dbz = d; dut_zero = z; clear = clr; rst = r;
        if (r) begin
            pend.delete();
            repeat (LAT) pend.push_back(5'b0);
            m_pulse = 0; m_vec = 0; m_sticky = 0;
            m_chk = 0; m_err = 0; m_chk4 = 0; m_err4 = 0;
        end else begin
            tail = pend.pop_front();
            pend.push_back((v && op <= 3'd3) ? {1'b1, predict(a, b, op)} : 5'b0);
            if (clr) begin
                m_chk = 0; m_err = 0; m_chk4 = 0; m_err4 = 0; m_sticky = 0;
            end
            m_pulse = 0;
            if (tail[4]) begin
                vec[0] = q != tail[3];
                vec[1] = tail[2] & !i;
                vec[2] = d != tail[1];
                vec[3] = tail[0] & !z;
                vec[4] = (cls(o) == C_NAN) != q;
                m_vec = vec;
                m_pulse = |vec;
                m_sticky = m_sticky | vec;
                if (m_chk < 65535) m_chk++;
                if (m_chk4 < 15) m_chk4++;
                if (|vec) begin
                    if (m_err < 65535) m_err++;
                    if (m_err4 < 15) m_err4++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit clr);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, clr, 0);
    endtask

    task automatic drain_clear();
        repeat (LAT) idle(0);
        idle(1);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] x = $urandom;
        case ($urandom_range(0, 7))
            0: x = {x[31], 31'h0};
            1: x = {x[31], 8'hFF, 23'h0};
            2: x = {x[31], 8'hFF, x[22:1], 1'b1};
            3: x = {x[31], 8'h00, x[22:1], 1'b1};
            default: x = {x[31], 8'($urandom_range(1, 254)), x[22:0]};
        endcase
        return x;
    endfunction

    task automatic test_reset();
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset pulse: got %0h want 0", err_pulse); end
        checks++; if (err_vec !== 5'b0) begin errors++; $display("FAIL reset vec: got %b want 00000", err_vec); end
        checks++; if (err_sticky !== 5'b0) begin errors++; $display("FAIL reset sticky: got %b want 00000", err_sticky); end
        checks++; if (chk_cnt !== 16'd0) begin errors++; $display("FAIL reset chk_cnt: got %0d want 0", chk_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_nan_add();
        drain_clear();
        tick(1, 32'h7FC00000, 32'h3F800000, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT - 1) idle(0);
        tick(0, 0, 0, 0, 32'h7FC00000, 1, 0, 0, 0, 0, 0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL nan_add pulse: got %0h want 0", err_pulse); end
        checks++; if (chk_cnt !== 16'd1) begin errors++; $display("FAIL nan_add chk_cnt: got %0d want 1", chk_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL nan_add err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_dbz();
        drain_clear();
        tick(1, 32'h40000000, 32'h00000000, 3'd3, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT - 1) idle(0);
        tick(0, 0, 0, 0, 32'h7F800000, 0, 1, 0, 0, 0, 0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL dbz pulse: got %0h want 1", err_pulse); end
        checks++; if (err_vec !== 5'b00100) begin errors++; $display("FAIL dbz vec: got %b want 00100", err_vec); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL dbz err_cnt: got %0d want 1", err_cnt); end
        checks++; if (err_sticky !== 5'b00100) begin errors++; $display("FAIL dbz sticky: got %b want 00100", err_sticky); end
        idle(0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL dbz pulse_drop: got %0h want 0", err_pulse); end
        checks++; if (err_vec !== 5'b00100) begin errors++; $display("FAIL dbz vec_hold: got %b want 00100", err_vec); end
    endtask

    task automatic test_inf_minus_inf();
        drain_clear();
        tick(1, 32'h7F800000, 32'hFF800000, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT - 1) idle(0);
        tick(0, 0, 0, 0, 32'h7F800000, 1, 0, 0, 0, 0, 0);
        checks++; if (err_vec !== 5'b10000) begin errors++; $display("FAIL inf_inf vec: got %b want 10000", err_vec); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL inf_inf pulse: got %0h want 1", err_pulse); end
    endtask

    task automatic test_back_to_back();
        drain_clear();
        for (int k = 0; k < 10 + LAT; k++) begin
            tick(k < 10, 32'h00000000, 32'h7F800000, 3'd2, 32'h7FC00000, 1, 0, 0, 0, 0, 0);
            checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL b2b pulse[%0d]: got %0h want 0", k, err_pulse); end
        end
        checks++; if (chk_cnt !== 16'd10) begin errors++; $display("FAIL b2b chk_cnt: got %0d want 10", chk_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL b2b err_cnt: got %0d want 0", err_cnt); end
        tick(1, 32'h00000000, 32'h7F800000, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT - 1) idle(0);
        tick(0, 0, 0, 0, 32'h00000000, 0, 0, 0, 0, 1, 0);
        checks++; if (chk_cnt !== 16'd1) begin errors++; $display("FAIL clr_cmp chk_cnt: got %0d want 1", chk_cnt); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL clr_cmp err_cnt: got %0d want 1", err_cnt); end
        checks++; if (err_sticky !== 5'b00001) begin errors++; $display("FAIL clr_cmp sticky: got %b want 00001", err_sticky); end
    endtask

    task automatic test_reset_mid();
        drain_clear();
        tick(1, 32'h40000000, 32'h00000000, 3'd3, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        tick(0, 0, 0, 0, 32'h7FC00000, 0, 0, 0, 0, 0, 0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_mid pulse: got %0h want 0", err_pulse); end
        checks++; if (err_vec !== 5'b0) begin errors++; $display("FAIL rst_mid vec: got %b want 00000", err_vec); end
        checks++; if (err_sticky !== 5'b0) begin errors++; $display("FAIL rst_mid sticky: got %b want 00000", err_sticky); end
        checks++; if (chk_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid chk_cnt: got %0d want 0", chk_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_saturation();
        drain_clear();
        for (int k = 0; k < 20 + LAT; k++)
            tick(k < 20, 32'h40000000, 32'h00000000, 3'd3, 32'h7F800000, 0, 1, 0, 0, 0, 0);
        checks++; if (chk_cnt4 !== 4'd15) begin errors++; $display("FAIL sat chk_cnt4: got %0d want 15", chk_cnt4); end
        checks++; if (err_cnt4 !== 4'd15) begin errors++; $display("FAIL sat err_cnt4: got %0d want 15", err_cnt4); end
        checks++; if (chk_cnt !== 16'd20) begin errors++; $display("FAIL sat chk_cnt: got %0d want 20", chk_cnt); end
        checks++; if (err_cnt !== 16'd20) begin errors++; $display("FAIL sat err_cnt: got %0d want 20", err_cnt); end
    endtask

    task automatic test_random();
        logic [3:0]  f;
        logic [31:0] o;
        bit          q, i, d, z;
        for (int k = 0; k < 400; k++) begin
            f = pend[0][3:0];
            if ($urandom_range(0, 3) != 0) begin
                q = f[3]; d = f[1];
                i = f[2] | ($urandom_range(0, 7) == 0);
                z = f[0] | ($urandom_range(0, 7) == 0);
                o = q ? 32'h7FC00001 : 32'h3F800000;
            end else begin
                {q, i, d, z} = 4'($urandom);
                o = rnd_operand();
            end
            tick($urandom_range(0, 9) != 0, rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)),
                 o, q, i, d, z, $urandom_range(0, 49) == 0, 0);
            checks++; if (err_pulse !== m_pulse || err_pulse4 !== m_pulse) begin errors++; $display("FAIL rnd pulse[%0d]: got %0h/%0h want %0h", k, err_pulse, err_pulse4, m_pulse); end
            checks++; if (err_vec !== m_vec || err_vec4 !== m_vec) begin errors++; $display("FAIL rnd vec[%0d]: got %b/%b want %b", k, err_vec, err_vec4, m_vec); end
            checks++; if (err_sticky !== m_sticky || err_sticky4 !== m_sticky) begin errors++; $display("FAIL rnd sticky[%0d]: got %b/%b want %b", k, err_sticky, err_sticky4, m_sticky); end
            checks++; if (chk_cnt !== 16'(m_chk) || chk_cnt4 !== 4'(m_chk4)) begin errors++; $display("FAIL rnd chk_cnt[%0d]: got %0d/%0d want %0d/%0d", k, chk_cnt, chk_cnt4, m_chk, m_chk4); end
            checks++; if (err_cnt !== 16'(m_err) || err_cnt4 !== 4'(m_err4)) begin errors++; $display("FAIL rnd err_cnt[%0d]: got %0d/%0d want %0d/%0d", k, err_cnt, err_cnt4, m_err, m_err4); end
        end
    endtask

    initial begin
        test_reset();
        test_nan_add();
        test_dbz();
        test_inf_minus_inf();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
